// File: rtl/pc_next_if.sv
// Control/datapath bundle for the next-PC unit: candidate sources and load controls in,
// PC state and debug status out.
interface pc_next_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 6,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
);
  logic [N_SRC*WIDTH-1:0] src_flat_i;
  logic [SEL_W-1:0]       sel_i;
  logic                   pc_write_i;
  logic                   pc_write_cond_i;
  logic                   cond_true_i;
  logic                   bad_sel_clr_i;
  logic                   count_clr_i;
  logic [WIDTH-1:0]       pc_o;
  logic [WIDTH-1:0]       pc_prev_o;
  logic [WIDTH-1:0]       target_o;
  logic                   bad_sel_o;
  logic                   misalign_o;
  logic [WIDTH-1:0]       bad_addr_o;
  logic [CNT_W-1:0]       redirect_count_o;

  modport master (
    output src_flat_i, sel_i, pc_write_i, pc_write_cond_i, cond_true_i,
           bad_sel_clr_i, count_clr_i,
    input  pc_o, pc_prev_o, target_o, bad_sel_o, misalign_o, bad_addr_o,
           redirect_count_o
  );

  modport slave (
    input  src_flat_i, sel_i, pc_write_i, pc_write_cond_i, cond_true_i,
           bad_sel_clr_i, count_clr_i,
    output pc_o, pc_prev_o, target_o, bad_sel_o, misalign_o, bad_addr_o,
           redirect_count_o
  );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC source mux plus PC register, with bad-select and alignment checking and a
// saturating redirect counter.
module pc_next_unit #(
  parameter int              WIDTH       = 32,
  parameter int              N_SRC       = 6,
  parameter int              SEL_W       = 3,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int              ALIGN_CHECK = 1,
  parameter int              CNT_W       = 8
) (
  input logic     clk,
  input logic     rst,
  pc_next_if.slave bus
);
  logic [WIDTH-1:0] target;
  logic             sel_ok;
  logic             load_req;
  logic             bad_load;
  logic             mis_load;
  logic             commit;

  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] pc_prev_q,  pc_prev_d;
  logic             bad_sel_q,  bad_sel_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] bad_addr_q, bad_addr_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // Out-of-range selects match no candidate, leaving target at zero.
  always_comb begin
    target = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.sel_i == SEL_W'(i)) begin
        target = bus.src_flat_i[i*WIDTH +: WIDTH];
        sel_ok = 1'b1;
      end
    end
  end

  assign load_req = bus.pc_write_i | (bus.pc_write_cond_i & bus.cond_true_i);
  assign bad_load = load_req & ~sel_ok;
  assign mis_load = load_req & sel_ok & (ALIGN_CHECK != 0) & (|target[1:0]);
  assign commit   = load_req & sel_ok & ~mis_load;

  always_comb begin
    pc_d       = pc_q;
    pc_prev_d  = pc_prev_q;
    bad_sel_d  = bad_sel_q;
    misalign_d = mis_load;
    bad_addr_d = bad_addr_q;
    cnt_d      = cnt_q;
    if (commit) begin
      pc_d      = target;
      pc_prev_d = pc_q;
      if (bus.sel_i != '0 && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end
    if (mis_load)
      bad_addr_d = target;
    if (bad_load)
      bad_sel_d = 1'b1;
    else if (bus.bad_sel_clr_i)
      bad_sel_d = 1'b0;
    if (bus.count_clr_i)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_prev_q  <= RESET_PC;
      bad_sel_q  <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_prev_q  <= pc_prev_d;
      bad_sel_q  <= bad_sel_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc_o             = pc_q;
  assign bus.pc_prev_o        = pc_prev_q;
  assign bus.target_o         = target;
  assign bus.bad_sel_o        = bad_sel_q;
  assign bus.misalign_o       = misalign_q;
  assign bus.bad_addr_o       = bad_addr_q;
  assign bus.redirect_count_o = cnt_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit (N_SRC=6, CNT_W=2 so saturation is reachable).
module tb_pc_next_unit;
  localparam int WIDTH = 32;
  localparam int N_SRC = 6;
  localparam int SEL_W = 3;
  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  pc_next_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  pc_next_unit #(
    .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .RESET_PC(32'h0),
    .ALIGN_CHECK(1), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic pw, input logic pwc, input logic ct,
                       input logic bclr, input logic cclr);
    bus.sel_i           = sel;
    bus.pc_write_i      = pw;
    bus.pc_write_cond_i = pwc;
    bus.cond_true_i     = ct;
    bus.bad_sel_clr_i   = bclr;
    bus.count_clr_i     = cclr;
  endtask

  task automatic set_src(input int idx, input logic [31:0] val);
    bus.src_flat_i[idx*WIDTH +: WIDTH] = val;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus.src_flat_i = '0;
    set_src(0, 32'h0000_0044);
    set_src(1, 32'h0000_0040);
    set_src(2, 32'h0000_0100);
    set_src(3, 32'h0000_0102);
    set_src(4, 32'h0000_0200);
    set_src(5, 32'h0000_0300);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset asserted between edges takes effect immediately
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_pc_prev", bus.pc_prev_o, 32'h0);
    chk("rst_bad_sel", 32'(bus.bad_sel_o), 32'h0);
    chk("rst_misalign", 32'(bus.misalign_o), 32'h0);
    chk("rst_bad_addr", bus.bad_addr_o, 32'h0);
    chk("rst_count", 32'(bus.redirect_count_o), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_pc", bus.pc_o, 32'h0);

    drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("target_sel1", bus.target_o, 32'h40);
    tick();
    chk("uncond_pc", bus.pc_o, 32'h40);
    chk("uncond_prev", bus.pc_prev_o, 32'h0);
    chk("uncond_cnt", 32'(bus.redirect_count_o), 32'd1);

    drive(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sel0_pc", bus.pc_o, 32'h44);
    chk("sel0_prev", bus.pc_prev_o, 32'h40);
    chk("sel0_cnt", 32'(bus.redirect_count_o), 32'd1);

    drive(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("cond_false_pc", bus.pc_o, 32'h44);
    drive(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("cond_true_pc", bus.pc_o, 32'h100);
    chk("cond_true_prev", bus.pc_prev_o, 32'h44);
    chk("cond_true_cnt", 32'(bus.redirect_count_o), 32'd2);

    drive(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("target_oor", bus.target_o, 32'h0);
    drive(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("badsel_pc", bus.pc_o, 32'h100);
    chk("badsel_flag", 32'(bus.bad_sel_o), 32'h1);
    chk("badsel_misalign", 32'(bus.misalign_o), 32'h0);
    chk("badsel_cnt", 32'(bus.redirect_count_o), 32'd2);
    drive(3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("badsel_set_wins", 32'(bus.bad_sel_o), 32'h1);
    chk("badsel6_pc", bus.pc_o, 32'h100);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("badsel_clr", 32'(bus.bad_sel_o), 32'h0);

    drive(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis_pc", bus.pc_o, 32'h100);
    chk("mis_pulse", 32'(bus.misalign_o), 32'h1);
    chk("mis_addr", bus.bad_addr_o, 32'h102);
    chk("mis_cnt", 32'(bus.redirect_count_o), 32'd2);
    drive(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis_drop", 32'(bus.misalign_o), 32'h0);

    drive(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis2_a", 32'(bus.misalign_o), 32'h1);
    set_src(3, 32'h0000_0203);
    tick();
    chk("mis2_b", 32'(bus.misalign_o), 32'h1);
    chk("mis2_addr", bus.bad_addr_o, 32'h203);
    drive(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis2_drop", 32'(bus.misalign_o), 32'h0);
    chk("mis2_addr_hold", bus.bad_addr_o, 32'h203);

    // both write requests with cond_true low still load once
    drive(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("both_pc", bus.pc_o, 32'h200);
    chk("both_prev", bus.pc_prev_o, 32'h100);
    chk("both_cnt", 32'(bus.redirect_count_o), 32'd3);
    drive(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat_pc", bus.pc_o, 32'h300);
    chk("sat_cnt", 32'(bus.redirect_count_o), 32'd3);

    drive(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("cclr_cnt", 32'(bus.redirect_count_o), 32'd0);
    chk("cclr_pc", bus.pc_o, 32'h200);
    chk("cclr_prev", bus.pc_prev_o, 32'h300);
    drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_clr_cnt", 32'(bus.redirect_count_o), 32'd1);
    chk("post_clr_pc", bus.pc_o, 32'h40);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    #3 rst = 1'b1;
    #1;
    chk("midrst_pc", bus.pc_o, 32'h0);
    chk("midrst_prev", bus.pc_prev_o, 32'h0);
    chk("midrst_cnt", 32'(bus.redirect_count_o), 32'd0);
    chk("midrst_bad_addr", bus.bad_addr_o, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised next-PC selector and program-counter register for the multicycle datapath. Selects one of N_SRC candidate addresses (PC+4, branch target, jump target, EPC, exception vectors, ...) and commits it to an internal PC register under unconditional or branch-conditional write control. Adds out-of-range select detection, word-alignment checking with faulting-address capture, and a saturating redirect counter for debug. Sits between the control unit and instruction-memory address path, replacing the fixed 6-input PC-source mux plus separate PC register.

## Interface
- WIDTH, 32, address width in bits
- N_SRC, 6, number of candidate sources (2..16)
- SEL_W, 3, select width; must satisfy 2^SEL_W >= N_SRC
- RESET_PC, 0, PC value loaded on reset
- ALIGN_CHECK, 1, 1 = reject targets with addr[1:0] != 0
- CNT_W, 8, redirect counter width

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- src_flat  in  N_SRC*WIDTH  candidate i at bits [i*WIDTH +: WIDTH]
- sel  in  SEL_W  source index
- pc_write  in  1  unconditional load request
- pc_write_cond  in  1  conditional load request (branch)
- cond_true  in  1  branch condition from ALU
- bad_sel_clr  in  1  clears bad_sel flag
- count_clr  in  1  clears redirect_count
- pc  out  WIDTH  current PC
- pc_prev  out  WIDTH  PC value before the most recent committed load
- target  out  WIDTH  combinational selected candidate (0 when sel out of range)
- bad_sel  out  1  sticky: load requested with sel >= N_SRC
- misalign  out  1  one-cycle pulse: load rejected for misalignment
- bad_addr  out  WIDTH  last rejected misaligned target
- redirect_count  out  CNT_W  committed loads with sel != 0, saturating

## Operation
- load_req = pc_write | (pc_write_cond & cond_true). Nothing below happens when load_req = 0 (sel is don't-care).
- Priority when load_req = 1:
  1. sel >= N_SRC: PC holds, bad_sel set. Alignment not evaluated; misalign stays 0.
  2. ALIGN_CHECK = 1 and target[1:0] != 0: PC holds, misalign = 1 next cycle, bad_addr <= target.
  3. Otherwise commit: pc <= target, pc_prev <= pc; if sel != 0, redirect_count increments unless at all-ones.
- bad_sel: set wins over bad_sel_clr in the same cycle; otherwise clr drops it.
- count_clr wins over increment in the same cycle (result 0).
- misalign is a registered pulse: high exactly one cycle per rejected load; back-to-back rejects keep it high, bad_addr updated each.
- pc_write and pc_write_cond both high: treated as a single load (unconditional dominates).
- Reset values: pc = RESET_PC, pc_prev = RESET_PC, bad_sel = 0, misalign = 0, bad_addr = 0, redirect_count = 0. Reset asserted mid-operation forces these immediately, independent of clk.

## Timing
- target: combinational from src_flat/sel, same cycle.
- pc, pc_prev, bad_sel, misalign, bad_addr, redirect_count: registered, update on the rising edge that samples load_req; visible the following cycle.
- Load latency 1 cycle; a new load may be issued every cycle.
- No combinational path from any input to pc.

## Test plan
- Reset: assert reset between edges -> pc = RESET_PC (0x0) immediately, all flags/counters 0; release, no loads -> pc stable.
- Unconditional load: src1 = 0x0000_0040, sel = 1, pc_write = 1 one cycle -> next cycle pc = 0x40, pc_prev = 0x0, redirect_count = 1; sel = 0 with src0 = 0x44 -> pc = 0x44, count stays 1.
- Conditional: pc_write_cond = 1, cond_true = 0, sel = 2 (0x100) -> pc unchanged; cond_true = 1 -> pc = 0x100.
- Bad select (N_SRC = 6): sel = 7, pc_write = 1 -> pc holds, bad_sel = 1, misalign = 0, target = 0; bad_sel_clr with another sel = 6 load same cycle -> bad_sel stays 1; clr alone -> 0.
- Misalign: sel = 3, src3 = 0x0000_0102 -> pc holds, misalign high one cycle, bad_addr = 0x102; two consecutive rejects -> misalign high two cycles.
- Counter saturation (CNT_W = 2): four redirect loads -> count = 3, stays 3; count_clr with simultaneous redirect -> 0.
